ex_mem_reg: RTL and testbench

EX→MEM pipeline register of the five-stage core; captures EX results each cycle and presents them, registered, to the memory stage (`me_*` signals). Holds on stall, inserts a bubble on flush, and rejects misaligned loads/stores by suppressing their memory and register-file effects while raising a trap flag. Also generates the memory stage's store-data forward select from the writeback-stage destination.

---
 rtl/ex_mem_reg.sv | 186 ++++++++++++++++++
 tb/tb_ex_mem_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// ex_mem_reg -- EX->MEM pipeline register of the five-stage core.
//
// Captures the EX-stage results on every rising clock edge and presents them,
// registered, to the memory stage. The capture priority is:
// reset > flush > stall > load.
//  - A flush inserts a bubble: every field is zero.
//  - A stall holds every field.
//  - On a load, the fields follow ex_*. When ex_valid is low, the control bits
//    are captured as zero.
//
// Misaligned loads and stores are trapped. A halfword access with addr[0] set,
// or a word access with addr[1:0] nonzero, raises me_misalign. The same access
// has its memory enables and its register write suppressed. The address, data
// and funct3 are still captured so the trap handler can report them.
//
// forward_data is combinational from the MEM-side registers and the WB-stage
// destination. It tells the memory stage to take the WB result as the store
// data.
//
// Optional feature: define EX_MEM_PERF_EN to enable two performance counters.
//  - perf_mem_ops counts aligned, valid memory operations as they are captured.
//  - perf_stall_cycles counts the cycles where stall is high and flush is low.
// When EX_MEM_PERF_EN is undefined, both counters read 32'h0.
//
// Ports:
//   clk, rst            core clock; synchronous active-high reset
//   ex_*                EX-stage instruction fields (inputs)
//   stall, flush        pipeline hold / bubble controls
//   w_rd, w_regs_write  WB-stage destination, used for store-data forwarding
//   me_*                registered MEM-stage fields (outputs)
//   me_misalign         misaligned-access trap for the MEM instruction
//   forward_data        select the WB result as the store data
//   perf_mem_ops, perf_stall_cycles   performance counters

module ex_mem_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_o,
    input  logic [31:0] ex_regs_data2,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regs_write,
    input  logic        ex_mem2reg,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_func3_code,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  w_rd,
    input  logic        w_regs_write,
    output logic        me_valid,
    output logic [31:0] me_alu_o,
    output logic [31:0] me_regs_data2,
    output logic [4:0]  me_rd,
    output logic        me_regs_write,
    output logic        me_mem2reg,
    output logic        me_mem_read,
    output logic        me_mem_write,
    output logic [2:0]  me_func3_code,
    output logic        me_misalign,
    output logic        forward_data,
    output logic [31:0] perf_mem_ops,
    output logic [31:0] perf_stall_cycles
);

    // Size field funct3[1:0]: 00 byte, 01 halfword, 10 word.
    // A byte access is never misaligned.
    function automatic logic addr_misaligned(input logic [1:0] addr_lo,
                                             input logic [1:0] size);
        logic mis;
        case (size)
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    logic        valid_r;
    logic [31:0] alu_r;
    logic [31:0] data2_r;
    logic [4:0]  rs2_r;
    logic [4:0]  rd_r;
    logic        regs_write_r;
    logic        mem2reg_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [2:0]  func3_r;
    logic        misalign_r;

    logic        mem_op_s;
    logic        misalign_s;
    logic        ctrl_ok_s;
    logic        count_mem_op_s;
    logic        forward_s;

    // Gating of incoming control bits: drop them for EX bubbles and misaligned accesses.
    always_comb begin
        mem_op_s       = 1'b0;
        misalign_s     = 1'b0;
        ctrl_ok_s      = 1'b0;
        count_mem_op_s = 1'b0;
        mem_op_s       = ex_mem_read | ex_mem_write;
        misalign_s     = ex_valid & mem_op_s
                         & addr_misaligned(ex_alu_o[1:0], ex_func3_code[1:0]);
        ctrl_ok_s      = ex_valid & ~misalign_s;
        count_mem_op_s = ctrl_ok_s & mem_op_s;
    end

    // Pipeline register: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_r      <= 1'b0;
            alu_r        <= 32'h0;
            data2_r      <= 32'h0;
            rs2_r        <= 5'd0;
            rd_r         <= 5'd0;
            regs_write_r <= 1'b0;
            mem2reg_r    <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            func3_r      <= 3'd0;
            misalign_r   <= 1'b0;
        end else if (!stall) begin
            valid_r      <= ex_valid;
            alu_r        <= ex_alu_o;
            data2_r      <= ex_regs_data2;
            rs2_r        <= ex_rs2;
            rd_r         <= ex_rd;
            regs_write_r <= ex_regs_write & ctrl_ok_s;
            mem2reg_r    <= ex_mem2reg & ex_valid;
            mem_read_r   <= ex_mem_read & ctrl_ok_s;
            mem_write_r  <= ex_mem_write & ctrl_ok_s;
            func3_r      <= ex_func3_code;
            misalign_r   <= misalign_s;
        end
    end

    assign me_valid      = valid_r;
    assign me_alu_o      = alu_r;
    assign me_regs_data2 = data2_r;
    assign me_rd         = rd_r;
    assign me_regs_write = regs_write_r;
    assign me_mem2reg    = mem2reg_r;
    assign me_mem_read   = mem_read_r;
    assign me_mem_write  = mem_write_r;
    assign me_func3_code = func3_r;
    assign me_misalign   = misalign_r;

    // Store-data forward select; x0 is never a forwarding source.
    always_comb begin
        forward_s = 1'b0;
        forward_s = valid_r & mem_write_r & w_regs_write
                    & (w_rd != 5'd0) & (w_rd == rs2_r);
    end

    assign forward_data = forward_s;

`ifdef EX_MEM_PERF_EN
    logic [31:0] mem_ops_r;
    logic [31:0] stall_cycles_r;

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ops_r      <= 32'h0;
            stall_cycles_r <= 32'h0;
        end else if (flush) begin
            mem_ops_r      <= mem_ops_r;
            stall_cycles_r <= stall_cycles_r;
        end else if (stall) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else if (count_mem_op_s) begin
            mem_ops_r      <= mem_ops_r + 32'd1;
        end
    end

    assign perf_mem_ops      = mem_ops_r;
    assign perf_stall_cycles = stall_cycles_r;
`else
    assign perf_mem_ops      = 32'h0;
    assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

`ifdef EX_MEM_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_regs_write, ex_mem2reg, ex_mem_read, ex_mem_write;
    logic [31:0] ex_alu_o, ex_regs_data2;
    logic [4:0]  ex_rs2, ex_rd, w_rd;
    logic [2:0]  ex_func3_code;
    logic        stall, flush, w_regs_write;
    logic        me_valid, me_regs_write, me_mem2reg, me_mem_read, me_mem_write;
    logic        me_misalign, forward_data;
    logic [31:0] me_alu_o, me_regs_data2, perf_mem_ops, perf_stall_cycles;
    logic [4:0]  me_rd;
    logic [2:0]  me_func3_code;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_o(ex_alu_o),
        .ex_regs_data2(ex_regs_data2), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regs_write(ex_regs_write), .ex_mem2reg(ex_mem2reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_func3_code(ex_func3_code), .stall(stall), .flush(flush),
        .w_rd(w_rd), .w_regs_write(w_regs_write), .me_valid(me_valid),
        .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2), .me_rd(me_rd),
        .me_regs_write(me_regs_write), .me_mem2reg(me_mem2reg),
        .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
        .me_func3_code(me_func3_code), .me_misalign(me_misalign),
        .forward_data(forward_data), .perf_mem_ops(perf_mem_ops),
        .perf_stall_cycles(perf_stall_cycles)
    );

    // Reference model: the MEM slot as an abstract record.
    typedef struct {
        bit          valid;
        bit   [31:0] alu, d2;
        bit   [4:0]  rs2, rd;
        bit          rw, m2r, mr, mw;
        bit   [2:0]  f3;
        bit          mis;
        bit   [31:0] ops, stc;
    } slot_t;

    slot_t m;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit is_mis(input bit [31:0] a, input bit [2:0] f3);
        int unsigned sz;
        sz = f3 % 4;
        return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    endfunction

    task automatic model_update();
        bit v, memop, mis;
        if (rst) begin
            m = '{default: 0};
        end else if (flush) begin
            m.valid = 0; m.alu = 0; m.d2 = 0; m.rs2 = 0; m.rd = 0;
            m.rw = 0; m.m2r = 0; m.mr = 0; m.mw = 0; m.f3 = 0; m.mis = 0;
        end else if (stall) begin
            m.stc = m.stc + 1;
        end else begin
            v     = ex_valid;
            memop = ex_mem_read || ex_mem_write;
            mis   = v && memop && is_mis(ex_alu_o, ex_func3_code);
            m.valid = v;
            m.alu = ex_alu_o; m.d2 = ex_regs_data2; m.rs2 = ex_rs2; m.rd = ex_rd;
            m.f3  = ex_func3_code;
            m.mis = mis;
            m.m2r = v && ex_mem2reg;
            m.rw  = v && !mis && ex_regs_write;
            m.mr  = v && !mis && ex_mem_read;
            m.mw  = v && !mis && ex_mem_write;
            if (v && memop && !mis) m.ops = m.ops + 1;
        end
    endtask

    task automatic chk_fwd(input string tag);
        bit e;
        e = m.valid && m.mw && w_regs_write && (w_rd != 0) && (w_rd == m.rs2);
        chk(tag, forward_data, e);
    endtask

    task automatic check_all();
        chk("me_valid", me_valid, m.valid);
        chk("me_alu_o", me_alu_o, m.alu);
        chk("me_regs_data2", me_regs_data2, m.d2);
        chk("me_rd", me_rd, m.rd);
        chk("me_regs_write", me_regs_write, m.rw);
        chk("me_mem2reg", me_mem2reg, m.m2r);
        chk("me_mem_read", me_mem_read, m.mr);
        chk("me_mem_write", me_mem_write, m.mw);
        chk("me_func3_code", me_func3_code, m.f3);
        chk("me_misalign", me_misalign, m.mis);
        chk("perf_mem_ops", perf_mem_ops, PERF ? m.ops : 32'h0);
        chk("perf_stall_cycles", perf_stall_cycles, PERF ? m.stc : 32'h0);
        chk_fwd("forward_data");
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic set_ex(input bit v, input bit [31:0] a, input bit [31:0] d,
                          input bit [4:0] r2, input bit [4:0] rd, input bit rw,
                          input bit m2r, input bit mr, input bit mw, input bit [2:0] f3);
        ex_valid = v; ex_alu_o = a; ex_regs_data2 = d; ex_rs2 = r2; ex_rd = rd;
        ex_regs_write = rw; ex_mem2reg = m2r; ex_mem_read = mr; ex_mem_write = mw;
        ex_func3_code = f3;
    endtask

    task automatic rand_ex();
        set_ex($urandom_range(0, 1) == 1, $urandom, $urandom, 5'($urandom_range(0, 7)),
               5'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom));
    endtask

    initial begin
        m = '{default: 0};
        rst = 1'b1; stall = 1'b0; flush = 1'b0; w_rd = 5'd0; w_regs_write = 1'b0;
        rand_ex();
        tick();
        chk("reset_valid", me_valid, 32'h0);
        chk("reset_alu", me_alu_o, 32'h0);

        // lw at 0x100
        rst = 1'b0;
        set_ex(1, 32'h100, 32'h0, 5'd0, 5'd3, 1, 1, 1, 0, 3'b010);
        tick();
        chk("lw_mem_read", me_mem_read, 32'h1);
        chk("lw_alu", me_alu_o, 32'h100);
        chk("lw_misalign", me_misalign, 32'h0);

        // sw held across three stall cycles, forwarding checked while held
        set_ex(1, 32'h200, 32'hdeadbeef, 5'd5, 5'd0, 0, 0, 0, 1, 3'b010);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            tick();
            chk("stall_alu", me_alu_o, 32'h200);
            chk("stall_mem_write", me_mem_write, 32'h1);
        end
        w_rd = 5'd5; w_regs_write = 1'b1; #1;
        chk("fwd_match", forward_data, 32'h1);
        w_regs_write = 1'b0; #1;
        chk("fwd_no_wb_write", forward_data, 32'h0);
        w_rd = 5'd6; w_regs_write = 1'b1; #1;
        chk("fwd_other_rd", forward_data, 32'h0);
        flush = 1'b1;
        tick();
        chk("flush_valid", me_valid, 32'h0);
        chk("flush_mem_write", me_mem_write, 32'h0);
        stall = 1'b0; flush = 1'b0;

        // misalignment cases
        set_ex(1, 32'h101, 32'h0, 5'd0, 5'd4, 1, 1, 1, 0, 3'b001);
        tick();
        chk("lh_misalign", me_misalign, 32'h1);
        chk("lh_mem_read", me_mem_read, 32'h0);
        chk("lh_regs_write", me_regs_write, 32'h0);
        chk("lh_alu", me_alu_o, 32'h101);
        set_ex(1, 32'h102, 32'h0, 5'd0, 5'd4, 1, 1, 1, 0, 3'b010);
        tick();
        chk("lw102_misalign", me_misalign, 32'h1);
        set_ex(1, 32'h103, 32'h0, 5'd0, 5'd4, 1, 1, 1, 0, 3'b000);
        tick();
        chk("lb_misalign", me_misalign, 32'h0);
        chk("lb_mem_read", me_mem_read, 32'h1);

        // forwarding: x0 never forwards; loads never forward
        set_ex(1, 32'h300, 32'h0, 5'd0, 5'd0, 0, 0, 0, 1, 3'b010);
        w_rd = 5'd0; w_regs_write = 1'b1;
        tick();
        chk("fwd_x0", forward_data, 32'h0);
        set_ex(1, 32'h304, 32'h0, 5'd5, 5'd7, 1, 1, 1, 0, 3'b010);
        w_rd = 5'd5;
        tick();
        chk("fwd_load", forward_data, 32'h0);

        // EX bubble with a stray store bit
        set_ex(0, 32'h400, 32'h0, 5'd5, 5'd0, 0, 0, 0, 1, 3'b010);
        tick();
        chk("bubble_valid", me_valid, 32'h0);
        chk("bubble_mem_write", me_mem_write, 32'h0);

        // counters: 4 aligned ops, 1 misaligned, 2 stalls + 1 stall with flush
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ex(1, 32'h1000 + 32'(i * 4), 32'h0, 5'd1, 5'd2, 1, 1, 1, 0, 3'b010);
            tick();
        end
        set_ex(1, 32'h1001, 32'h0, 5'd1, 5'd2, 0, 0, 0, 1, 3'b010);
        tick();
        stall = 1'b1; tick(); tick();
        flush = 1'b1; tick();
        stall = 1'b0; flush = 1'b0;
        chk("cnt_mem_ops", perf_mem_ops, PERF ? 32'd4 : 32'd0);
        chk("cnt_stall", perf_stall_cycles, PERF ? 32'd2 : 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_ex();
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 6);
            stall = ($urandom_range(0, 99) < 20);
            w_rd  = 5'($urandom_range(0, 7));
            w_regs_write = $urandom_range(0, 1) == 1;
            #1;
            chk_fwd("rand_fwd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
